// File: rtl/mul_sequencer_if.sv
// Decoder <-> multiply unit signal bundle.
// The decoder side (master) issues starts and HI/LO reads; the unit (slave) answers.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             domul;
  logic             is_signed;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             multoreg;
  logic             lohi;
  logic [WIDTH-1:0] mulresult;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output domul, is_signed, srca, srcb, multoreg, lohi,
    input  mulresult, busy, done, stall
  );

  modport slave (
    input  domul, is_signed, srca, srcb, multoreg, lohi,
    output mulresult, busy, done, stall
  );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier with architectural HI/LO registers.
// Signed operands are reduced to magnitudes up front and the sign is
// applied once at the end, so one unsigned datapath serves MULT and MULTU.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave mif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               start_ok;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] res;

  // Operand magnitudes; |-2^(W-1)| = 2^(W-1) still fits unsigned in WIDTH bits.
  always_comb begin
    mag_a = (mif.is_signed && mif.srca[WIDTH-1]) ? (~mif.srca) + WIDTH'(1) : mif.srca;
    mag_b = (mif.is_signed && mif.srcb[WIDTH-1]) ? (~mif.srcb) + WIDTH'(1) : mif.srcb;
  end

  // Next-state and datapath: one add-and-shift per RUN cycle, sign fix in FIX.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sum      = '0;
    res      = '0;
    start_ok = (state_q == S_IDLE) || (state_q == S_DONE);

    case (state_q)
      S_RUN: begin
        // Carry out of the upper-half add is kept and shifted back in.
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        res     = neg_q ? (~acc_q) + (2*WIDTH)'(1) : acc_q;
        hi_d    = res[2*WIDTH-1:WIDTH];
        lo_d    = res[WIDTH-1:0];
        state_d = S_DONE;
      end
      default: begin
        // IDLE and DONE both accept a new start; a busy unit ignores domul.
        state_d = S_IDLE;
        if (start_ok && mif.domul) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = mif.is_signed & (mif.srca[WIDTH-1] ^ mif.srcb[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
    endcase
  end

  // State registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status decoded straight from the state flops; read path is zero-latency.
  assign mif.busy      = (state_q == S_RUN) || (state_q == S_FIX);
  assign mif.done      = (state_q == S_DONE);
  assign mif.stall     = mif.multoreg & mif.busy;
  assign mif.mulresult = mif.lohi ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboarded bench for mul_sequencer: stimulus pushes the expected product
// and completion cycle, a monitor pops and checks on every done pulse.
module tb_mul_sequencer;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    int unsigned    due;
  } exp_t;
  exp_t sbq[$];

  logic mon_active = 1'b0;
  logic mon_lohi = 1'b0;
  logic stim_lohi = 1'b0;

  mul_sequencer_if #(.WIDTH(W)) mif ();
  assign mif.lohi = mon_active ? mon_lohi : stim_lohi;

  mul_sequencer #(.WIDTH(W), .CNTW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: the full-precision product by plain arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Drives a one-cycle start at a negedge; returns on the following negedge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    exp_t e;
    mif.domul = 1'b1; mif.srca = a; mif.srcb = b; mif.is_signed = s;
    if (push) begin
      e.prod = ref_mul(a, b, s);
      e.due  = cyc + 1 + LAT;
      sbq.push_back(e);
    end
    @(negedge clk);
    mif.domul = 1'b0;
  endtask

  // Waits for the done pulse, counting busy cycles seen on the way.
  task automatic wait_done(output int nb);
    bit seen = 0;
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      #3;
      if (mif.done) begin seen = 1; break; end
      if (mif.busy) nb++;
      @(negedge clk);
    end
    if (!seen) chk("done_timeout", 1'b0, 1'b1);
  endtask

  // Monitor: stall rule every cycle, scoreboard pop on every done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("stall_rule", mif.stall, mif.multoreg & mif.busy);
      if (mif.done) begin
        chk("done_expected", (sbq.size() > 0), 1'b1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.due);
          mon_active = 1'b1;
          mon_lohi   = 1'b0;
          #1 chk("lo", mif.mulresult, e.prod[W-1:0]);
          mon_lohi   = 1'b1;
          #1 chk("hi", mif.mulresult, e.prod[2*W-1:W]);
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    int nb;
    logic [W-1:0] a, b;
    logic s;
    mif.domul = 1'b0; mif.is_signed = 1'b0; mif.srca = '0; mif.srcb = '0;
    mif.multoreg = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy", mif.busy, 1'b0);
    chk("rst_done", mif.done, 1'b0);
    chk("rst_stall", mif.stall, 1'b0);
    stim_lohi = 1'b0; #1 chk("rst_lo", mif.mulresult, '0);
    stim_lohi = 1'b1; #1 chk("rst_hi", mif.mulresult, '0);
    stim_lohi = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // MULTU max x max, busy length
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
    wait_done(nb);
    chk("multu_busy_cycles", nb, LAT);
    @(negedge clk);

    // MULT -3 x 7 and the most-negative corner
    start(32'hFFFF_FFFD, 32'd7, 1'b1, 1);
    wait_done(nb);
    @(negedge clk);
    start(32'h8000_0000, 32'h8000_0000, 1'b1, 1);
    wait_done(nb);
    @(negedge clk);

    // Stall while reading LO of 6x7
    start(32'd6, 32'd7, 1'b0, 1);
    mif.multoreg = 1'b1; stim_lohi = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #3;
      if (!mif.busy) break;
      chk("stall_hold", mif.stall, 1'b1);
      @(negedge clk);
    end
    chk("stall_release", mif.stall, 1'b0);
    chk("stall_read_lo", mif.mulresult, 64'd42);
    mif.multoreg = 1'b0;
    @(negedge clk);

    // Start while busy is ignored
    start(32'd1234, 32'd5678, 1'b0, 1);
    repeat (4) @(negedge clk);
    start(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 0);
    wait_done(nb);

    // Chained start in the DONE cycle
    start(32'hFFFF_FFFF, 32'd2, 1'b1, 1);
    #3 chk("chain_busy", mif.busy, 1'b1);
    wait_done(nb);
    @(negedge clk);

    // Reset mid-operation
    start(32'd2, 32'd3, 1'b0, 1);
    wait_done(nb);
    @(negedge clk);
    start(32'd5, 32'd5, 1'b0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("abort_busy", mif.busy, 1'b0);
    chk("abort_done", mif.done, 1'b0);
    stim_lohi = 1'b0; #1 chk("abort_lo", mif.mulresult, '0);
    stim_lohi = 1'b1; #1 chk("abort_hi", mif.mulresult, '0);
    stim_lohi = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3 chk("abort_no_done", mif.done, 1'b0);
    end
    chk("abort_idle", mif.busy, 1'b0);

    // Randomized operations with random gaps (gap 0 chains in DONE)
    for (int k = 0; k < 20; k++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = '0;
        1: b = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      start(a, b, s, 1);
      wait_done(nb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
